pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised pipeline hazard controller for the rv32i core, generalising the fixed five-stage stall/flush logic to an N-stage pipeline. It detects load-use hazards, back-end stalls (data memory, multiply/divide), and taken-branch redirects, and drives per-latch load and flush vectors plus PC/fetch enables. A small state machine tracks wrong-path instruction fetches that are still in flight when a redirect occurs and discards them on return.

## Interface
- `NUM_STAGES`, 5: pipeline depth, ≥5; stage 0 = IF, 1 = ID, 2 = EX, `NUM_STAGES-2` = MEM, `NUM_STAGES-1` = WB.
- `BR_STAGE`, 2: stage in which redirects resolve, 2..`NUM_STAGES-2`.
- `CNT_W`, 32: performance counter width.
- Reset is asynchronous and active-high. Clocking is on the rising edge of `clk`. Outputs are forced to their reset values while `rst` is high.
- `clk`  in  1  core clock
- `rst`  in  1  async active-high reset
- `imem_resp`  in  1  instruction fetch response this cycle
- `dmem_req`  in  1  MEM-stage read or write outstanding
- `dmem_resp`  in  1  data response this cycle
- `md_busy`  in  1  EX-stage multiply/divide running, not complete
- `redirect`  in  1  taken branch/jump resolved in `BR_STAGE`
- `ex_is_load`  in  1  EX-stage instruction is a load
- `ex_rd`  in  5  EX-stage destination
- `id_rs1`, `id_rs2`  in  5 each  ID-stage sources
- `id_use_rs1`, `id_use_rs2`  in  1 each  source actually read
- `load_pc`  out  1  PC register enable
- `inst_read`  out  1  issue fetch request
- `load_latch`  out  `NUM_STAGES-1`  enable for latch k (feeds stage k+1)
- `flush_latch`  out  `NUM_STAGES-1`  latch k captures a bubble on the next edge
- `state`  out  2  FSM state (debug)

## Operation
- FSM states:
  - RUN=0: normal.
  - SQUASH=1: a wrong-path fetch is outstanding.
- Conditions, evaluated each cycle:
  - back-end stall B = (`dmem_req` & !`dmem_resp`) | `md_busy`.
  - load-use U = `ex_is_load` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
  - fetch stall F = !`imem_resp`.
- Priority is B > redirect > U > F. Defaults: all loads 1, all flushes 0, `load_pc`=1, `inst_read`=1.
- B: all `load_latch`=0 and `load_pc`=0; flushes remain 0. `redirect` and U are ignored while B holds. EX is frozen, so they re-present when B clears.
- redirect (RUN):
  - `load_pc`=1 to take the target.
  - `flush_latch[k]`=1 for all k < `BR_STAGE`.
  - If F is also true, go to SQUASH.
- U: `load_pc`=0, `load_latch[0]`=0, `flush_latch[1]`=1 (bubble into EX). Latches ≥2 advance.
- F (RUN): `load_pc`=0, `flush_latch[0]`=1. Later latches advance.
- SQUASH:
  - `load_pc`=0, `inst_read`=0, `flush_latch[0]`=1.
  - On `imem_resp`, discard the response and return to RUN. `inst_read` re-asserts the following cycle, fetching the target.
  - A further `redirect` in SQUASH updates the PC (`load_pc`=1) and remains in SQUASH.
  - B in SQUASH freezes latches but still exits SQUASH on `imem_resp`.

## Timing
- All control outputs are combinational from inputs plus `state`. There is zero-cycle latency from a hazard to the enables.
- `state` updates on the rising edge of `clk`.
- Load-use costs exactly 1 bubble. A redirect costs `BR_STAGE` bubbles, plus the wait for the outstanding fetch if one is in flight.
- Reset values:
  - `state`=RUN.
  - `load_pc`=0, `inst_read`=0.
  - `load_latch`=0, `flush_latch`=all ones.
  - Counters are 0.
- Reset asserted mid-SQUASH drops to RUN immediately. A stale `imem_resp` after reset is the fetch unit's responsibility.
- Counters saturate at 2^`CNT_W`−1 and do not wrap.
- Simultaneous `dmem_resp` and `dmem_req` counts as no stall that cycle.

## Configuration
- `PIPE_HAZARD_PERF_EN` defined:
  - Adds outputs `stall_cycles`, `bubble_count`, and `squash_count`, each `CNT_W` bits.
  - `stall_cycles` increments each cycle B or F is true.
  - `bubble_count` increments per U bubble.
  - `squash_count` increments on each SQUASH entry.
- `PIPE_HAZARD_PERF_EN` undefined: the ports and registers are absent, and control behaviour is identical.

## Test plan
- Load-use: `ex_is_load`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 -> `load_pc`=0, `load_latch`=4'b1110, `flush_latch`=4'b0010 for one cycle. Repeat with `ex_rd`=0 -> no stall.
- D-miss: `dmem_req`=1 for 6 cycles with concurrent `redirect`=1 -> `load_latch`=0 for 6 cycles. On the `dmem_resp` cycle, the redirect flush `flush_latch`=4'b0011 occurs.
- Redirect with fetch outstanding: `redirect`=1, `imem_resp`=0 -> SQUASH. `imem_resp` arrives 3 cycles later -> `flush_latch[0]`=1 on that cycle, back to RUN, `inst_read`=1 on the next cycle.
- `NUM_STAGES`=7, `BR_STAGE`=4: a redirect flushes latches 0–3 only (`flush_latch`=6'b001111).
- Async `rst` pulse mid-SQUASH with no clock edge -> `state`=RUN immediately and `flush_latch` all ones. With `PIPE_HAZARD_PERF_EN` and `CNT_W`=4: 20 stall cycles -> `stall_cycles`=15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// N-stage stall/flush/redirect control with wrong-path fetch squash.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/bubble/squash counters.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 5,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    imem_resp,
  input  logic                    dmem_req,
  input  logic                    dmem_resp,
  input  logic                    md_busy,
  input  logic                    redirect,
  input  logic                    ex_is_load,
  input  logic [4:0]              ex_rd,
  input  logic [4:0]              id_rs1,
  input  logic [4:0]              id_rs2,
  input  logic                    id_use_rs1,
  input  logic                    id_use_rs2,
  output logic                    load_pc,
  output logic                    inst_read,
  output logic [NUM_STAGES-2:0]   load_latch,
  output logic [NUM_STAGES-2:0]   flush_latch,
  output logic [1:0]              state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cycles,
  output logic [CNT_W-1:0]        bubble_count,
  output logic [CNT_W-1:0]        squash_count
`endif
);

  localparam int NL = NUM_STAGES - 1;
  localparam logic [NL-1:0] RD_MASK = NL'((1 << BR_STAGE) - 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1
  } st_t;

  if (NUM_STAGES < 5 || BR_STAGE < 2 || BR_STAGE > NUM_STAGES - 2 ||
      CNT_W < 1) begin : g_bad_cfg
    $error("pipe_hazard_ctrl: illegal parameters");
  end

  st_t  state_q, state_d;
  logic b, u, f;

  assign b = (dmem_req & ~dmem_resp) | md_busy;
  assign u = ex_is_load & (ex_rd != 5'd0) &
             ((id_use_rs1 & (id_rs1 == ex_rd)) |
              (id_use_rs2 & (id_rs2 == ex_rd)));
  assign f = ~imem_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d     = state_q;
    load_pc     = 1'b1;
    inst_read   = 1'b1;
    load_latch  = '1;
    flush_latch = '0;
    if (rst) begin
      load_pc     = 1'b0;
      inst_read   = 1'b0;
      load_latch  = '0;
      flush_latch = '1;
    end else begin
      // The response that ends SQUASH is the wrong-path one; drop it.
      if (state_q == SQUASH) begin
        load_pc        = 1'b0;
        inst_read      = 1'b0;
        flush_latch[0] = 1'b1;
        if (imem_resp) state_d = RUN;
      end
      if (b) begin
        load_pc     = 1'b0;
        load_latch  = '0;
        flush_latch = '0;
      end else if (redirect) begin
        load_pc     = 1'b1;
        flush_latch = flush_latch | RD_MASK;
        if (state_q == RUN && f) state_d = SQUASH;
      end else if (u) begin
        load_pc        = 1'b0;
        load_latch[0]  = 1'b0;
        flush_latch[1] = 1'b1;
      end else if (f && state_q == RUN) begin
        load_pc        = 1'b0;
        flush_latch[0] = 1'b1;
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic bub, sq_enter;

  assign bub      = ~b & ~redirect & u;
  assign sq_enter = (state_q == RUN) & ~b & redirect & f;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      bubble_count <= '0;
      squash_count <= '0;
    end else begin
      if ((b | f) && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (bub && bubble_count != '1)
        bubble_count <= bubble_count + CNT_W'(1);
      if (sq_enter && squash_count != '1)
        squash_count <= squash_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default 5-stage and a 7-stage
// instance (BR_STAGE=4, CNT_W=4) share the same stimulus.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic imem_resp, dmem_req, dmem_resp, md_busy, redirect, ex_is_load;
  logic [4:0] ex_rd, id_rs1, id_rs2;
  logic id_use_rs1, id_use_rs2;

  logic       lpc5, ird5, lpc7, ird7;
  logic [3:0] ll5, fl5;
  logic [5:0] ll7, fl7;
  logic [1:0] st5, st7;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] sc5, bc5, qc5;
  logic [3:0]  sc7, bc7, qc7;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u5 (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .md_busy(md_busy), .redirect(redirect),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .load_pc(lpc5), .inst_read(ird5), .load_latch(ll5),
    .flush_latch(fl5), .state(st5)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cycles(sc5), .bubble_count(bc5), .squash_count(qc5)
`endif
  );

  pipe_hazard_ctrl #(.NUM_STAGES(7), .BR_STAGE(4), .CNT_W(4)) u7 (
    .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_req(dmem_req),
    .dmem_resp(dmem_resp), .md_busy(md_busy), .redirect(redirect),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1),
    .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .load_pc(lpc7), .inst_read(ird7), .load_latch(ll7),
    .flush_latch(fl7), .state(st7)
`ifdef PIPE_HAZARD_PERF_EN
    , .stall_cycles(sc7), .bubble_count(bc7), .squash_count(qc7)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    md_busy = 1'b0; redirect = 1'b0; ex_is_load = 1'b0;
    ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #3;
    chk("rst_lpc", lpc5, 0);
    chk("rst_ird", ird5, 0);
    chk("rst_ll", ll5, 4'h0);
    chk("rst_fl", fl5, 4'hF);
    chk("rst_fl7", fl7, 6'h3F);
    chk("rst_st", st5, 0);
    cyc();
    rst = 1'b0;
    #1;
    chk("run_ll", ll5, 4'hF);
    chk("run_fl", fl5, 4'h0);
    chk("run_lpc", lpc5, 1);
    chk("run_ird", ird5, 1);

    // load-use on rs1
    ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    chk("lu_lpc", lpc5, 0);
    chk("lu_ll", ll5, 4'b1110);
    chk("lu_fl", fl5, 4'b0010);
    chk("lu_ll7", ll7, 6'b111110);
    chk("lu_fl7", fl7, 6'b000010);
    ex_rd = 5'd0; id_rs1 = 5'd0;
    #1;
    chk("lu0_lpc", lpc5, 1);
    chk("lu0_ll", ll5, 4'hF);
    chk("lu0_fl", fl5, 4'h0);
    // rs2 match, used then unused
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7;
    id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
    #1;
    chk("lu2_fl", fl5, 4'b0010);
    id_use_rs2 = 1'b0;
    #1;
    chk("lu2n_fl", fl5, 4'b0000);
    chk("lu2n_lpc", lpc5, 1);
    idle();
    cyc();

    // d-miss with concurrent redirect
    dmem_req = 1'b1; redirect = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("dm_ll", ll5, 4'h0);
      chk("dm_fl", fl5, 4'h0);
      chk("dm_lpc", lpc5, 0);
      cyc();
    end
    dmem_resp = 1'b1;
    #1;
    chk("dmr_fl", fl5, 4'b0011);
    chk("dmr_fl7", fl7, 6'b001111);
    chk("dmr_ll", ll5, 4'hF);
    chk("dmr_lpc", lpc5, 1);
    cyc();
    chk("dmr_st", st5, 0);
    idle();

    // md_busy stall
    md_busy = 1'b1;
    #1;
    chk("md_ll", ll5, 4'h0);
    chk("md_lpc", lpc5, 0);
    idle();

    // fetch stall in RUN
    imem_resp = 1'b0;
    #1;
    chk("f_lpc", lpc5, 0);
    chk("f_fl", fl5, 4'b0001);
    chk("f_ll", ll5, 4'hF);
    chk("f_ird", ird5, 1);
    cyc();
    chk("f_st", st5, 0);

    // redirect with fetch outstanding
    redirect = 1'b1;
    #1;
    chk("rs_lpc", lpc5, 1);
    chk("rs_fl", fl5, 4'b0011);
    cyc();
    chk("rs_st", st5, 1);
    redirect = 1'b0;
    #1;
    chk("sq_lpc", lpc5, 0);
    chk("sq_ird", ird5, 0);
    chk("sq_fl", fl5, 4'b0001);
    chk("sq_ll", ll5, 4'hF);
    cyc();
    redirect = 1'b1;
    #1;
    chk("sqr_lpc", lpc5, 1);
    chk("sqr_ird", ird5, 0);
    cyc();
    chk("sqr_st", st5, 1);
    redirect = 1'b0; imem_resp = 1'b1;
    #1;
    chk("sqx_fl", fl5, 4'b0001);
    chk("sqx_ird", ird5, 0);
    cyc();
    chk("sqx_st", st5, 0);
    chk("sqx_ird2", ird5, 1);
    chk("sqx_lpc", lpc5, 1);

    // async reset while in SQUASH
    redirect = 1'b1; imem_resp = 1'b0;
    cyc();
    chk("ar_pre", st7, 1);
    redirect = 1'b0;
    rst = 1'b1;
    #1;
    chk("ar_st", st5, 0);
    chk("ar_st7", st7, 0);
    chk("ar_fl", fl5, 4'hF);
    chk("ar_ll", ll5, 4'h0);
    idle();
    #1;
    rst = 1'b0;
    cyc();
    chk("ar_post", st5, 0);

`ifdef PIPE_HAZARD_PERF_EN
    chk("pf_sc0", sc7, 0);
    imem_resp = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    imem_resp = 1'b1;
    #1;
    chk("pf_sc7", sc7, 15);
    chk("pf_sc5", sc5, 20);
    ex_is_load = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
    cyc();
    idle();
    chk("pf_bc", bc5, 1);
    redirect = 1'b1; imem_resp = 1'b0;
    cyc();
    idle();
    chk("pf_qc", qc5, 1);
    cyc();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
